// File: rtl/synth_pkg.sv
// Shared definitions for the PDM decimation datapath: CIC order, comb
// sequencer states and the CIC register width derived from the decimation.
package synth_pkg;

    localparam int CIC_ORDER = 3;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        COMB1 = 3'd1,
        COMB2 = 3'd2,
        COMB3 = 3'd3,
        EMIT  = 3'd4
    } comb_state_t;

    // Bit growth of an order-N CIC is N*log2(R); two extra bits leave room
    // for the +/-1 input and the sign.
    function automatic int cic_width(input int decim_log2);
        return CIC_ORDER * decim_log2 + 2;
    endfunction

endpackage

// File: rtl/cic_integ_chain.sv
// Three cascaded CIC integrators fed by a +/-1 bitstream. All arithmetic
// wraps modulo 2^W; the comb section downstream undoes the wrap exactly.
module cic_integ_chain #(
    parameter int W = 35
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    input  logic         in_bit,
    output logic [W-1:0] out
);

    logic [W-1:0] step_s;
    logic [W-1:0] integ1_r;
    logic [W-1:0] integ2_r;
    logic [W-1:0] integ3_r;

    // Map the PDM bit to +1 / -1 in W-bit two's complement.
    always_comb begin
        step_s = {W{1'b1}};
        if (in_bit) begin
            step_s = {{(W-1){1'b0}}, 1'b1};
        end else begin
            step_s = {W{1'b1}};
        end
    end

    // Integrator cascade; each stage accumulates the previous stage's register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            integ1_r <= {W{1'b0}};
            integ2_r <= {W{1'b0}};
            integ3_r <= {W{1'b0}};
        end else if (en) begin
            integ1_r <= integ1_r + step_s;
            integ2_r <= integ2_r + integ1_r;
            integ3_r <= integ3_r + integ2_r;
        end
    end

    assign out = integ3_r;

endmodule

// File: rtl/pdm_decimator.sv
// PDM-to-PCM decimator: bit synchronizer, 3rd-order CIC (integrators in a
// sub-module, combs time-multiplexed by a small sequencer), scaling with
// saturation and a valid/ready output register with overrun signalling.
module pdm_decimator
    import synth_pkg::*;
#(
    parameter int DECIM_LOG2 = 11,
    parameter int OUT_W      = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             pdm_in,
    input  logic             pdm_en,
    output logic [OUT_W-1:0] sample_out,
    output logic             sample_valid,
    input  logic             sample_ready,
    output logic             overrun
);

    localparam int W     = cic_width(DECIM_LOG2);
    localparam int XW    = W + OUT_W;
    localparam int SHIFT = CIC_ORDER * DECIM_LOG2 - OUT_W + 1;
    // Small decimations need a left shift to reach full scale instead.
    localparam int unsigned RSH = (SHIFT > 0) ? SHIFT : 0;
    localparam int unsigned LSH = (SHIFT < 0) ? -SHIFT : 0;

    localparam logic [DECIM_LOG2-1:0] CNT_ONE = {{(DECIM_LOG2-1){1'b0}}, 1'b1};
    localparam logic [DECIM_LOG2-1:0] CNT_MAX = {DECIM_LOG2{1'b1}};
    localparam logic signed [XW-1:0]  SAT_MAX = {{(W+1){1'b0}}, {(OUT_W-1){1'b1}}};
    localparam logic signed [XW-1:0]  SAT_MIN = {{(W+1){1'b1}}, {(OUT_W-1){1'b0}}};

    logic [1:0]              sync_r;
    logic [1:0]              en_sync_r;
    logic [DECIM_LOG2-1:0]   cnt_r;
    logic                    strobe_r;
    logic [W-1:0]            integ_s;
    comb_state_t             state_r;
    logic signed [W-1:0]     data_r;
    logic signed [W-1:0]     d1_r;
    logic signed [W-1:0]     d2_r;
    logic signed [W-1:0]     d3_r;
    logic signed [XW-1:0]    ext_s;
    logic signed [XW-1:0]    shifted_s;
    logic [OUT_W-1:0]        sat_s;

    // Two-flop synchronizer for the bit; the enable travels alongside it.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync_r    <= 2'b00;
            en_sync_r <= 2'b00;
        end else begin
            sync_r    <= {sync_r[0], pdm_in};
            en_sync_r <= {en_sync_r[0], pdm_en};
        end
    end

    cic_integ_chain #(
        .W (W)
    ) u_integ (
        .clk    (clk),
        .rst    (rst),
        .en     (en_sync_r[1]),
        .in_bit (sync_r[1]),
        .out    (integ_s)
    );

    // Enabled-bit counter; the strobe marks the cycle after the R-th bit.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_r    <= {DECIM_LOG2{1'b0}};
            strobe_r <= 1'b0;
        end else if (en_sync_r[1]) begin
            cnt_r    <= cnt_r + CNT_ONE;
            strobe_r <= (cnt_r == CNT_MAX);
        end else begin
            strobe_r <= 1'b0;
        end
    end

    // Scale the final comb value to the output width and clamp to full scale.
    always_comb begin
        ext_s     = {{OUT_W{data_r[W-1]}}, data_r};
        shifted_s = (ext_s >>> RSH) <<< LSH;
        sat_s     = shifted_s[OUT_W-1:0];
        if (shifted_s > SAT_MAX) begin
            sat_s = SAT_MAX[OUT_W-1:0];
        end else if (shifted_s < SAT_MIN) begin
            sat_s = SAT_MIN[OUT_W-1:0];
        end else begin
            sat_s = shifted_s[OUT_W-1:0];
        end
    end

    // Comb sequencer plus output handshake; EMIT wins over a same-cycle accept.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r      <= IDLE;
            data_r       <= '0;
            d1_r         <= '0;
            d2_r         <= '0;
            d3_r         <= '0;
            sample_out   <= {OUT_W{1'b0}};
            sample_valid <= 1'b0;
            overrun      <= 1'b0;
        end else begin
            overrun <= 1'b0;
            if (sample_valid && sample_ready) begin
                sample_valid <= 1'b0;
            end
            case (state_r)
                IDLE: begin
                    if (strobe_r) begin
                        data_r  <= integ_s;
                        state_r <= COMB1;
                    end
                end
                COMB1: begin
                    data_r  <= data_r - d1_r;
                    d1_r    <= data_r;
                    state_r <= COMB2;
                end
                COMB2: begin
                    data_r  <= data_r - d2_r;
                    d2_r    <= data_r;
                    state_r <= COMB3;
                end
                COMB3: begin
                    data_r  <= data_r - d3_r;
                    d3_r    <= data_r;
                    state_r <= EMIT;
                end
                EMIT: begin
                    sample_out   <= sat_s;
                    sample_valid <= 1'b1;
                    overrun      <= sample_valid && !sample_ready;
                    state_r      <= IDLE;
                end
                default: begin
                    state_r <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pdm_decimator.sv
// Directed bench for pdm_decimator at the default decimation (R = 2048).
module tb_pdm_decimator;

    localparam int R = 2048;

    logic        clk = 1'b0;
    logic        rst;
    logic        pdm_in;
    logic        pdm_en;
    logic [15:0] sample_out;
    logic        sample_valid;
    logic        sample_ready;
    logic        overrun;

    int   errors = 0;
    int   checks = 0;
    int   cyc = 0;
    int   phase = 0;
    int   mode = 0;
    int   en_div = 1;
    int   ovr_cnt = 0;
    logic auto_ready = 1'b1;
    logic prev_valid = 1'b0;
    logic rise = 1'b0;

    pdm_decimator dut (
        .clk          (clk),
        .rst          (rst),
        .pdm_in       (pdm_in),
        .pdm_en       (pdm_en),
        .sample_out   (sample_out),
        .sample_valid (sample_valid),
        .sample_ready (sample_ready),
        .overrun      (overrun)
    );

    always #5 clk = ~clk;

    initial begin
        #1500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic set_inputs();
        if (mode == 0) pdm_in = 1'b1;
        else if (mode == 1) pdm_in = 1'b0;
        else pdm_in = phase[0];
        pdm_en = ((phase % en_div) == 0);
        sample_ready = auto_ready;
    endtask

    // One clock: sample outputs on the falling edge, then drive new inputs.
    task automatic tick();
        @(negedge clk);
        cyc++;
        rise = sample_valid && !prev_valid;
        prev_valid = sample_valid;
        if (overrun) ovr_cnt++;
        phase++;
        set_inputs();
    endtask

    task automatic do_reset(input int new_mode);
        rst = 1'b0;
        @(negedge clk);
        @(negedge clk);
        mode = new_mode;
        en_div = 1;
        phase = 0;
        set_inputs();
        rst = 1'b1;
        cyc = 0;
        prev_valid = 1'b0;
        ovr_cnt = 0;
    endtask

    task automatic wait_rise(input string tag, output int at, output int val);
        at = -1;
        val = 0;
        for (int i = 0; i < 4 * R + 40; i++) begin
            tick();
            if (rise) begin
                at = cyc;
                val = int'($signed(sample_out));
                return;
            end
        end
        check({tag, "_timeout"}, 0, 1);
    endtask

    initial begin
        int s1, s2, s3, s4, v;
        int ovr_at;
        logic valid_drop;

        rst = 1'b1;
        pdm_in = 1'b0;
        pdm_en = 1'b0;
        sample_ready = 1'b1;
        #2;
        rst = 1'b0;
        @(negedge clk);
        check("rst_out", int'($signed(sample_out)), 0);
        check("rst_valid", int'(sample_valid), 0);
        check("rst_overrun", int'(overrun), 0);

        // Constant +1: full positive scale saturates to 32767.
        do_reset(0);
        wait_rise("p_s1", s1, v);
        check("p_first_rise", s1, R + 7);
        wait_rise("p_s2", s2, v);
        check("p_period", s2 - s1, R);
        wait_rise("p_s3", s3, v);
        wait_rise("p_s4", s4, v);
        check("p_s4_val", v, 32767);
        check("p_no_overrun", ovr_cnt, 0);

        // Enable every 4th cycle: period 4R, value unchanged.
        en_div = 4;
        wait_rise("st_a", s1, v);
        wait_rise("st_b", s2, v);
        check("st_b_val", v, 32767);
        auto_ready = 1'b0;
        wait_rise("st_c", s3, v);
        check("st_period", s3 - s2, 4 * R);
        check("st_c_val", v, 32767);
        while (cyc < s3 + 4 * R - 2) tick();
        check("st_hold_valid", int'(sample_valid), 1);
        auto_ready = 1'b1;
        tick();
        auto_ready = 1'b0;
        tick();
        check("co_overrun", int'(overrun), 0);
        check("co_valid", int'(sample_valid), 1);
        tick();
        check("co_valid_kept", int'(sample_valid), 1);
        check("co_val", int'($signed(sample_out)), 32767);
        check("co_ovr_cnt", ovr_cnt, 0);
        auto_ready = 1'b1;
        tick();
        tick();
        check("co_consumed", int'(sample_valid), 0);

        // Constant -1, with the 3rd sample left unconsumed when the 4th lands.
        do_reset(1);
        wait_rise("n_s1", s1, v);
        wait_rise("n_s2", s2, v);
        auto_ready = 1'b0;
        wait_rise("n_s3", s3, v);
        check("n_s3_time", s3, 3 * R + 7);
        ovr_cnt = 0;
        ovr_at = -1;
        valid_drop = 1'b0;
        while (cyc < s3 + R + 3) begin
            tick();
            if (!sample_valid) valid_drop = 1'b1;
            if (overrun && ovr_at < 0) ovr_at = cyc;
        end
        check("ov_count", ovr_cnt, 1);
        check("ov_time", ovr_at, s3 + R);
        check("ov_valid_held", int'(valid_drop), 0);
        check("ov_val", int'($signed(sample_out)), -32768);
        auto_ready = 1'b1;
        tick();
        tick();
        check("ov_consumed", int'(sample_valid), 0);

        // Alternating 1,0: zero output, valid 5 cycles after each strobe.
        do_reset(2);
        wait_rise("a_s1", s1, v);
        check("a_first_rise", s1, R + 7);
        wait_rise("a_s2", s2, v);
        check("a_period2", s2 - s1, R);
        wait_rise("a_s3", s3, v);
        check("a_period3", s3 - s2, R);
        wait_rise("a_s4", s4, v);
        check("a_period4", s4 - s3, R);
        check("a_s4_val", v, 0);
        wait_rise("a_s5", s1, v);
        check("a_s5_val", v, 0);

        // Reset while the comb sequencer is in COMB2 of the 2nd sample.
        do_reset(0);
        auto_ready = 1'b0;
        wait_rise("r_s1", s1, v);
        check("r_s1_time", s1, R + 7);
        while (cyc < 2 * R + 4) tick();
        check("r_pre_valid", int'(sample_valid), 1);
        rst = 1'b0;
        #1;
        check("r_out", int'($signed(sample_out)), 0);
        check("r_valid", int'(sample_valid), 0);
        check("r_overrun", int'(overrun), 0);
        do_reset(2);
        auto_ready = 1'b1;
        wait_rise("r_next", s2, v);
        check("r_next_time", s2, R + 7);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
